// File: rtl/jtdd_romrd_pkg.sv
// Shared types and constants for the ROM read-back path.
package jtdd_romrd_pkg;

  localparam int unsigned NSLOT = 4;

  // Must match the layout used by the ROM downloader
  localparam logic [21:0] BankOffset  = 22'h00000;
  localparam logic [21:0] SndOffset   = 22'h14000;
  localparam logic [21:0] AdpcmOffset = 22'h18000;
  localparam logic [21:0] CharOffset  = 22'h28000;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } romrd_st_e;

  function automatic int unsigned max_aw(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/jtdd_romrd_slot.sv
// One-word cache entry for a single ROM read client: tag/data store, hit compare, miss flag.
module jtdd_romrd_slot #(
  parameter int unsigned AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [15:0]   fill_data,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          ok,
  output logic          miss,
  output logic [15:0]   dout
);

  logic          valid_q;
  logic [AW-1:0] tag_q;
  logic [15:0]   data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (fill) begin
      valid_q <= 1'b1;
      tag_q   <= fill_addr;
      data_q  <= fill_data;
    end
  end

  always_comb begin
    ok   = cs & valid_q & (tag_q == addr) & ~downloading;
    miss = cs & ~ok;
    dout = data_q;
  end

endmodule

// File: rtl/jtdd_rom_rd.sv
// Serialises four cached ROM read clients onto one SDRAM read port.
// Define JTDD_ROMRD_RROBIN_EN for round-robin arbitration; fixed priority (slot0 first) otherwise.
module jtdd_rom_rd
  import jtdd_romrd_pkg::*;
#(
  parameter int unsigned SLOT0_AW     = 17,
  parameter int unsigned SLOT1_AW     = 14,
  parameter int unsigned SLOT2_AW     = 16,
  parameter int unsigned SLOT3_AW     = 15,
  parameter logic [21:0] SLOT0_OFFSET = BankOffset,
  parameter logic [21:0] SLOT1_OFFSET = SndOffset,
  parameter logic [21:0] SLOT2_OFFSET = AdpcmOffset,
  parameter logic [21:0] SLOT3_OFFSET = CharOffset
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic                slot0_cs,
  input  logic [SLOT0_AW-1:0] slot0_addr,
  output logic                slot0_ok,
  output logic [15:0]         slot0_dout,
  input  logic                slot1_cs,
  input  logic [SLOT1_AW-1:0] slot1_addr,
  output logic                slot1_ok,
  output logic [15:0]         slot1_dout,
  input  logic                slot2_cs,
  input  logic [SLOT2_AW-1:0] slot2_addr,
  output logic                slot2_ok,
  output logic [15:0]         slot2_dout,
  input  logic                slot3_cs,
  input  logic [SLOT3_AW-1:0] slot3_addr,
  output logic                slot3_ok,
  output logic [15:0]         slot3_dout,
  output logic [21:0]         sdram_addr,
  output logic                sdram_req,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [15:0]         data_read
);

  localparam int unsigned LAW = max_aw(SLOT0_AW, SLOT1_AW, SLOT2_AW, SLOT3_AW);

  romrd_st_e        state_q;
  logic [1:0]       sel_q;
  logic [LAW-1:0]   laddr_q;
  logic             discard_q;
  logic [NSLOT-1:0] miss;
  logic [NSLOT-1:0] fill;
  logic [1:0]       win;
  logic             any_cand;
  logic [21:0]      req_addr [NSLOT];
  logic [LAW-1:0]   loc_addr [NSLOT];
`ifdef JTDD_ROMRD_RROBIN_EN
  logic [1:0]       last_q;
  logic [1:0]       idx;
`endif

  always_comb begin
    req_addr[0] = SLOT0_OFFSET + 22'(slot0_addr);
    req_addr[1] = SLOT1_OFFSET + 22'(slot1_addr);
    req_addr[2] = SLOT2_OFFSET + 22'(slot2_addr);
    req_addr[3] = SLOT3_OFFSET + 22'(slot3_addr);
    loc_addr[0] = LAW'(slot0_addr);
    loc_addr[1] = LAW'(slot1_addr);
    loc_addr[2] = LAW'(slot2_addr);
    loc_addr[3] = LAW'(slot3_addr);
  end

  always_comb begin
    win      = '0;
    any_cand = |miss;
`ifdef JTDD_ROMRD_RROBIN_EN
    idx = '0;
    // Scan from lowest to highest priority so the slot after last_q wins
    for (int i = NSLOT; i >= 1; i--) begin
      idx = last_q + 2'(i);
      if (miss[idx]) win = idx;
    end
`else
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (miss[i]) win = 2'(i);
    end
`endif
  end

  // A fetch that overlapped a download is completed but never cached
  always_comb begin
    fill = '0;
    if (state_q == StWait && data_rdy && !discard_q) fill[sel_q] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      laddr_q    <= '0;
      discard_q  <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
`ifdef JTDD_ROMRD_RROBIN_EN
      last_q     <= 2'd3;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_cand && !downloading) begin
            sel_q      <= win;
            laddr_q    <= loc_addr[win];
            sdram_addr <= req_addr[win];
            sdram_req  <= 1'b1;
            discard_q  <= 1'b0;
            state_q    <= StReq;
`ifdef JTDD_ROMRD_RROBIN_EN
            last_q     <= win;
`endif
          end
        end
        StReq: begin
          if (downloading) discard_q <= 1'b1;
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (downloading) discard_q <= 1'b1;
          if (data_rdy) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  jtdd_romrd_slot #(.AW(SLOT0_AW)) u_slot0 (
    .clk         (clk),
    .rst         (rst),
    .clr         (downloading),
    .fill        (fill[0]),
    .fill_addr   (laddr_q[SLOT0_AW-1:0]),
    .fill_data   (data_read),
    .downloading (downloading),
    .cs          (slot0_cs),
    .addr        (slot0_addr),
    .ok          (slot0_ok),
    .miss        (miss[0]),
    .dout        (slot0_dout)
  );

  jtdd_romrd_slot #(.AW(SLOT1_AW)) u_slot1 (
    .clk         (clk),
    .rst         (rst),
    .clr         (downloading),
    .fill        (fill[1]),
    .fill_addr   (laddr_q[SLOT1_AW-1:0]),
    .fill_data   (data_read),
    .downloading (downloading),
    .cs          (slot1_cs),
    .addr        (slot1_addr),
    .ok          (slot1_ok),
    .miss        (miss[1]),
    .dout        (slot1_dout)
  );

  jtdd_romrd_slot #(.AW(SLOT2_AW)) u_slot2 (
    .clk         (clk),
    .rst         (rst),
    .clr         (downloading),
    .fill        (fill[2]),
    .fill_addr   (laddr_q[SLOT2_AW-1:0]),
    .fill_data   (data_read),
    .downloading (downloading),
    .cs          (slot2_cs),
    .addr        (slot2_addr),
    .ok          (slot2_ok),
    .miss        (miss[2]),
    .dout        (slot2_dout)
  );

  jtdd_romrd_slot #(.AW(SLOT3_AW)) u_slot3 (
    .clk         (clk),
    .rst         (rst),
    .clr         (downloading),
    .fill        (fill[3]),
    .fill_addr   (laddr_q[SLOT3_AW-1:0]),
    .fill_data   (data_read),
    .downloading (downloading),
    .cs          (slot3_cs),
    .addr        (slot3_addr),
    .ok          (slot3_ok),
    .miss        (miss[3]),
    .dout        (slot3_dout)
  );

endmodule

// File: tb/tb_jtdd_rom_rd.sv
// Self-checking bench for jtdd_rom_rd: request-address scoreboard plus table and corner sequences.
module tb_jtdd_rom_rd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic        cs0 = 1'b0, cs1 = 1'b0, cs2 = 1'b0, cs3 = 1'b0;
  logic [16:0] a0 = '0;
  logic [13:0] a1 = '0;
  logic [15:0] a2 = '0;
  logic [14:0] a3 = '0;
  logic        slot0_ok, slot1_ok, slot2_ok, slot3_ok;
  logic [15:0] slot0_dout, slot1_dout, slot2_dout, slot3_dout;
  logic [21:0] sdram_addr;
  logic        sdram_req;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [15:0] data_read = '0;

  int total = 0;
  int bad = 0;
  logic [21:0] sb[$];
  logic req_prev = 1'b0;

  typedef struct {
    int          slot;
    logic [16:0] addr;
    logic [21:0] exp_addr;
    logic [15:0] data;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  jtdd_rom_rd dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .slot0_cs    (cs0),
    .slot0_addr  (a0),
    .slot0_ok    (slot0_ok),
    .slot0_dout  (slot0_dout),
    .slot1_cs    (cs1),
    .slot1_addr  (a1),
    .slot1_ok    (slot1_ok),
    .slot1_dout  (slot1_dout),
    .slot2_cs    (cs2),
    .slot2_addr  (a2),
    .slot2_ok    (slot2_ok),
    .slot2_dout  (slot2_dout),
    .slot3_cs    (cs3),
    .slot3_addr  (a3),
    .slot3_ok    (slot3_ok),
    .slot3_dout  (slot3_dout),
    .sdram_addr  (sdram_addr),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read)
  );

  // Every new request must match the oldest expected address
  always @(negedge clk) begin
    if (sdram_req && !req_prev) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_req: got addr %h, required no request", sdram_addr);
      end else begin
        logic [21:0] e;
        e = sb.pop_front();
        if (sdram_addr !== e) begin
          bad++;
          $display("FAIL sb_req_addr: got %h, required %h", sdram_addr, e);
        end
      end
    end
    req_prev = sdram_req;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_ok(input int s);
    case (s)
      0: return slot0_ok;
      1: return slot1_ok;
      2: return slot2_ok;
      default: return slot3_ok;
    endcase
  endfunction

  function automatic logic [15:0] get_dout(input int s);
    case (s)
      0: return slot0_dout;
      1: return slot1_dout;
      2: return slot2_dout;
      default: return slot3_dout;
    endcase
  endfunction

  task automatic set_slot(input int s, input logic [16:0] ad);
    case (s)
      0: begin cs0 = 1'b1; a0 = ad; end
      1: begin cs1 = 1'b1; a1 = ad[13:0]; end
      2: begin cs2 = 1'b1; a2 = ad[15:0]; end
      default: begin cs3 = 1'b1; a3 = ad[14:0]; end
    endcase
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    @(negedge clk);
    while (!sdram_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", 32'(sdram_req), 32'd1);
  endtask

  // Acks ad cycles after req is seen, data_rdy rd cycles after ack; returns in the ok cycle
  task automatic serve(input int ad, input int rd, input logic [15:0] d);
    wait_req();
    repeat (ad) step();
    sdram_ack = 1'b1;
    step();
    sdram_ack = 1'b0;
    repeat (rd - 1) step();
    data_rdy  = 1'b1;
    data_read = d;
    step();
    data_rdy  = 1'b0;
  endtask

  task automatic check_slot(input string name, input int s, input logic [15:0] d);
    @(negedge clk);
    check({name, "_ok"}, 32'(get_ok(s)), 32'd1);
    check({name, "_dout"}, 32'(get_dout(s)), 32'(d));
  endtask

  initial begin
    vecs[0] = '{0, 17'h1FFFF, 22'h01FFFF, 16'h1111};
    vecs[1] = '{1, 17'h03FFF, 22'h017FFF, 16'h2222};
    vecs[2] = '{2, 17'h00000, 22'h018000, 16'h3333};
    vecs[3] = '{2, 17'h0FFFF, 22'h027FFF, 16'h4444};
    vecs[4] = '{3, 17'h07FFF, 22'h02FFFF, 16'h5555};
    vecs[5] = '{3, 17'h00000, 22'h028000, 16'h6666};

    // Reset state
    repeat (3) step();
    @(negedge clk);
    check("rst_req", 32'(sdram_req), 32'd0);
    check("rst_addr", 32'(sdram_addr), 32'd0);
    check("rst_ok", {28'd0, slot3_ok, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
    check("rst_dout0", 32'(slot0_dout), 32'd0);
    check("rst_dout3", 32'(slot3_dout), 32'd0);
    rst = 1'b0;

    // Exact miss timing: cs at cycle 0, ack at 3, data at 6, ok at 7
    step();
    cs0 = 1'b1; a0 = 17'h00010; sb.push_back(22'h00010);
    @(negedge clk); check("c0_req", 32'(sdram_req), 32'd0);
    step();
    @(negedge clk); check("c1_req", 32'(sdram_req), 32'd1);
    check("c1_addr", 32'(sdram_addr), 32'h00010);
    step();
    step(); sdram_ack = 1'b1;
    @(negedge clk); check("c3_req_held", 32'(sdram_req), 32'd1);
    step(); sdram_ack = 1'b0;
    @(negedge clk); check("c4_req_drop", 32'(sdram_req), 32'd0);
    step();
    step(); data_rdy = 1'b1; data_read = 16'hBEEF;
    @(negedge clk); check("c6_ok", 32'(slot0_ok), 32'd0);
    step(); data_rdy = 1'b0;
    check_slot("c7", 0, 16'hBEEF);

    // Hit: no request over several cycles; then address change misses at once
    repeat (3) step();
    @(negedge clk);
    check("hit_ok", 32'(slot0_ok), 32'd1);
    check("hit_noreq", 32'(sdram_req), 32'd0);
    step();
    a0 = 17'h00011; sb.push_back(22'h00011);
    #1; check("addr_chg_ok", 32'(slot0_ok), 32'd0);
    serve(1, 1, 16'hC0DE);
    check_slot("refetch", 0, 16'hC0DE);

    // Simultaneous slot1/slot3 misses
    step();
    set_slot(1, 17'h2); set_slot(3, 17'h4);
    sb.push_back(22'h14002); sb.push_back(22'h28004);
    serve(1, 2, 16'h1234);
    check_slot("s1", 1, 16'h1234);
    check("s3_pending", 32'(slot3_ok), 32'd0);
    serve(2, 1, 16'h5678);
    check_slot("s3", 3, 16'h5678);

    // After slot3, simultaneous slot0/slot1 misses serve slot0 first
    step();
    set_slot(0, 17'h20); set_slot(1, 17'h3);
    sb.push_back(22'h00020); sb.push_back(22'h14003);
    serve(1, 1, 16'hAAAA);
    check_slot("s0_first", 0, 16'hAAAA);
    check("s1_second_pending", 32'(slot1_ok), 32'd0);
    serve(1, 1, 16'hBBBB);
    check_slot("s1_second", 1, 16'hBBBB);

    // Table: offset arithmetic at slot address extremes
    for (int i = 0; i < 6; i++) begin
      step();
      set_slot(vecs[i].slot, vecs[i].addr);
      sb.push_back(vecs[i].exp_addr);
      @(negedge clk);
      check($sformatf("vec%0d_miss", i), 32'(get_ok(vecs[i].slot)), 32'd0);
      serve(1 + i % 2, 1 + i % 3, vecs[i].data);
      check_slot($sformatf("vec%0d", i), vecs[i].slot, vecs[i].data);
    end

    // Slot2 address changes during WAIT: old tag cached, new request follows
    step();
    set_slot(2, 17'h100); sb.push_back(22'h18100);
    wait_req();
    step(); sdram_ack = 1'b1;
    step(); sdram_ack = 1'b0;
    a2 = 16'h0101; sb.push_back(22'h18101);
    step(); data_rdy = 1'b1; data_read = 16'h0BAD;
    step(); data_rdy = 1'b0;
    @(negedge clk); check("s2_stale_ok", 32'(slot2_ok), 32'd0);
    serve(1, 1, 16'h600D);
    check_slot("s2_new", 2, 16'h600D);

    // Downloading during WAIT: fetch completes but is discarded, no requests while high
    step();
    cs0 = 1'b0; cs1 = 1'b0; cs2 = 1'b0;
    a3 = 15'h0001; sb.push_back(22'h28001);
    wait_req();
    step(); sdram_ack = 1'b1;
    step(); sdram_ack = 1'b0; downloading = 1'b1;
    step(); data_rdy = 1'b1; data_read = 16'hDEAD;
    step(); data_rdy = 1'b0; a3 = 15'h0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("dl_noreq%0d", i), 32'(sdram_req), 32'd0);
      check($sformatf("dl_ok%0d", i), 32'(slot3_ok), 32'd0);
      step();
    end
    downloading = 1'b0; sb.push_back(22'h28000);
    #1; check("dl_cleared", 32'(slot3_ok), 32'd0);
    serve(1, 1, 16'h7777);
    check_slot("dl_refetch", 3, 16'h7777);
    step();
    a3 = 15'h0001; sb.push_back(22'h28001);
    #1; check("dl_discarded", 32'(slot3_ok), 32'd0);
    serve(1, 1, 16'h8888);
    check_slot("dl_refetch2", 3, 16'h8888);

    // Reset pulsed during REQ
    step();
    cs3 = 1'b0;
    set_slot(0, 17'h55); sb.push_back(22'h00055);
    wait_req();
    step(); rst = 1'b1;
    step(); rst = 1'b0; sb.push_back(22'h00055);
    @(negedge clk);
    check("rstreq_req", 32'(sdram_req), 32'd0);
    check("rstreq_ok", {28'd0, slot3_ok, slot2_ok, slot1_ok, slot0_ok}, 32'd0);
    serve(1, 1, 16'h9999);
    check_slot("rstreq_idle", 0, 16'h9999);

    repeat (3) step();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
